// File: rtl/topk_tracker.sv
// ---------------------------------------------------------------------------
// topk_tracker
//   Streaming top-K tracker. Keeps the K largest unsigned samples accepted
//   since the last reset/clear in a sorted register array (rank 0 = largest).
//   Each rank has its own comparator; an insertion is a single-cycle
//   parallel shift, so one sample per cycle is accepted with no stall.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   din_valid  in   sample offered this cycle
//   din        in   sample value (unsigned)
//   clear      in   synchronous flush, wins over din_valid
//   rank_sel   in   rank to read on dout/rank_valid
//   dout       out  value at rank_sel, 0 when that rank is unoccupied
//   rank_valid out  rank_sel is occupied
//   ranks      out  all ranks, rank r at [r*DATA_WIDTH +: DATA_WIDTH]
//   count      out  number of occupied ranks, saturating at K
// ---------------------------------------------------------------------------
module topk_tracker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K          = 4,
    parameter bit          UNIQUE     = 1'b0,
    localparam int unsigned RANK_W    = $clog2(K),
    localparam int unsigned CNT_W     = $clog2(K + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    din_valid,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    clear,
    input  logic [RANK_W-1:0]       rank_sel,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rank_valid,
    output logic [K*DATA_WIDTH-1:0] ranks,
    output logic [CNT_W-1:0]        count
);

    logic [DATA_WIDTH-1:0] r_val [K];
    logic [K-1:0]          r_occ;
    logic [CNT_W-1:0]      r_count;

    logic [DATA_WIDTH-1:0] w_val_nxt [K];
    logic [K-1:0]          w_occ_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [K-1:0]          w_gt;
    logic                  w_dup;
    logic                  w_accept;

    // w_gt[r]: din belongs at or above rank r. Because occupancy is contiguous
    // and values are non-increasing, w_gt is thermometer-coded (0..0 1..1),
    // so the insertion point is the first set bit.
    always_comb begin
        w_dup = 1'b0;
        for (int r = 0; r < int'(K); r++) begin
            w_gt[r] = !r_occ[r] || (din > r_val[r]);
            w_dup   = w_dup | (r_occ[r] && (din == r_val[r]));
        end
        w_accept = din_valid && !clear && !(UNIQUE && w_dup);
    end

    // Next rank value: hold, din (insertion point) or the rank above (shift).
    always_comb begin
        for (int r = 0; r < int'(K); r++) begin
            w_val_nxt[r] = r_val[r];
            w_occ_nxt[r] = r_occ[r];
        end
        w_count_nxt = r_count;
        if (w_accept) begin
            if (w_gt[0]) begin
                w_val_nxt[0] = din;
                w_occ_nxt[0] = 1'b1;
            end
            for (int r = 1; r < int'(K); r++) begin
                if (w_gt[r-1]) begin
                    w_val_nxt[r] = r_val[r-1];
                    w_occ_nxt[r] = r_occ[r-1];
                end else if (w_gt[r]) begin
                    w_val_nxt[r] = din;
                    w_occ_nxt[r] = 1'b1;
                end
            end
            // w_gt[K-1] set means some insertion point exists.
            if (w_gt[K-1] && (r_count != CNT_W'(K))) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < int'(K); r++) begin
                r_val[r] <= '0;
            end
            r_occ   <= '0;
            r_count <= '0;
        end else if (clear) begin
            for (int r = 0; r < int'(K); r++) begin
                r_val[r] <= '0;
            end
            r_occ   <= '0;
            r_count <= '0;
        end else begin
            for (int r = 0; r < int'(K); r++) begin
                r_val[r] <= w_val_nxt[r];
            end
            r_occ   <= w_occ_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        dout       = '0;
        rank_valid = 1'b0;
        ranks      = '0;
        for (int r = 0; r < int'(K); r++) begin
            ranks[r*DATA_WIDTH +: DATA_WIDTH] = r_occ[r] ? r_val[r] : '0;
            if (rank_sel == RANK_W'(r)) begin
                rank_valid = r_occ[r];
                dout       = r_occ[r] ? r_val[r] : '0;
            end
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_topk_tracker.sv
// ---------------------------------------------------------------------------
// tb_topk_tracker
//   Drives four topk_tracker instances (K=4, K=4 unique, K=2, K=8 unique)
//   from a shared stimulus stream and compares each against a sorted-list
//   reference model (descending list, truncated to K).
// ---------------------------------------------------------------------------
module tb_topk_tracker;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        din_valid = 1'b0;
    logic [31:0] din = '0;
    logic        clear = 1'b0;
    logic [2:0]  rs = '0;

    logic [31:0]  dout_a, dout_b, dout_c, dout_d;
    logic         rv_a, rv_b, rv_c, rv_d;
    logic [127:0] ranks_a, ranks_b;
    logic [63:0]  ranks_c;
    logic [255:0] ranks_d;
    logic [2:0]   cnt_a, cnt_b;
    logic [1:0]   cnt_c;
    logic [3:0]   cnt_d;

    int n_checks = 0;
    int n_errors = 0;

    bit [31:0] mq [4][$];

    always #5 clk = ~clk;

    topk_tracker #(.DATA_WIDTH(32), .K(4), .UNIQUE(1'b0)) u_k4 (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rs[1:0]), .dout(dout_a), .rank_valid(rv_a), .ranks(ranks_a), .count(cnt_a)
    );
    topk_tracker #(.DATA_WIDTH(32), .K(4), .UNIQUE(1'b1)) u_k4u (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rs[1:0]), .dout(dout_b), .rank_valid(rv_b), .ranks(ranks_b), .count(cnt_b)
    );
    topk_tracker #(.DATA_WIDTH(32), .K(2), .UNIQUE(1'b0)) u_k2 (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rs[0]), .dout(dout_c), .rank_valid(rv_c), .ranks(ranks_c), .count(cnt_c)
    );
    topk_tracker #(.DATA_WIDTH(32), .K(8), .UNIQUE(1'b1)) u_k8u (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rs), .dout(dout_d), .rank_valid(rv_d), .ranks(ranks_d), .count(cnt_d)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sorted descending list, truncated to k entries.
    task automatic model_ins(input int i, input int k, input bit uniq, input bit [31:0] v);
        int p;
        if (uniq) begin
            foreach (mq[i][j]) if (mq[i][j] == v) return;
        end
        p = mq[i].size();
        for (int j = 0; j < mq[i].size(); j++) begin
            if (v > mq[i][j]) begin
                p = j;
                break;
            end
        end
        if (p >= k) return;
        mq[i].insert(p, v);
        if (mq[i].size() > k) void'(mq[i].pop_back());
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mq[i].delete();
    endtask

    task automatic check_inst(input string name, input int i, input logic [255:0] g_ranks,
                              input logic [31:0] g_cnt, input logic [31:0] g_dout,
                              input logic g_rv, input int idx);
        logic [255:0] e_ranks;
        logic [31:0]  e_dout;
        e_ranks = '0;
        for (int j = 0; j < mq[i].size(); j++) e_ranks[j*32 +: 32] = mq[i][j];
        e_dout = (idx < mq[i].size()) ? mq[i][idx] : 32'd0;
        chk({name, ".ranks"}, g_ranks, e_ranks);
        chk({name, ".count"}, 256'(g_cnt), 256'(mq[i].size()));
        chk({name, ".dout"}, 256'(g_dout), 256'(e_dout));
        chk({name, ".rank_valid"}, 256'(g_rv), 256'(idx < mq[i].size()));
    endtask

    task automatic check_all();
        check_inst("k4", 0, {128'd0, ranks_a}, 32'(cnt_a), dout_a, rv_a, int'(rs[1:0]));
        check_inst("k4u", 1, {128'd0, ranks_b}, 32'(cnt_b), dout_b, rv_b, int'(rs[1:0]));
        check_inst("k2", 2, {192'd0, ranks_c}, 32'(cnt_c), dout_c, rv_c, int'(rs[0]));
        check_inst("k8u", 3, ranks_d, 32'(cnt_d), dout_d, rv_d, int'(rs));
    endtask

    // Called at a negedge; applies one cycle of stimulus and checks after the edge.
    task automatic step(input logic dv, input logic [31:0] d, input logic cl);
        din_valid = dv;
        din       = d;
        clear     = cl;
        @(posedge clk);
        if (cl) model_clear();
        else if (dv) begin
            model_ins(0, 4, 1'b0, d);
            model_ins(1, 4, 1'b1, d);
            model_ins(2, 2, 1'b0, d);
            model_ins(3, 8, 1'b1, d);
        end
        @(negedge clk);
        din_valid = 1'b0;
        clear     = 1'b0;
        check_all();
    endtask

    // Reset asserted between edges; outputs must drop without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        resetn = 1'b0;
        model_clear();
        #1;
        chk({tag, ".rst_ranks"}, {128'd0, ranks_a} | ranks_d, 256'd0);
        chk({tag, ".rst_count"}, 256'({cnt_a, cnt_d}), 256'd0);
        chk({tag, ".rst_dout"}, 256'(dout_a | dout_d), 256'd0);
        chk({tag, ".rst_rv"}, 256'({rv_a, rv_d}), 256'd0);
        @(negedge clk);
        resetn = 1'b1;
        check_all();
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rs = 3'd0;
        check_all();

        // Fill and order.
        step(1'b1, 32'd5, 1'b0);
        step(1'b1, 32'd9, 1'b0);
        step(1'b1, 32'd1, 1'b0);
        step(1'b1, 32'd7, 1'b0);
        chk("fill.ranks", {128'd0, ranks_a}, {128'd0, 32'd1, 32'd5, 32'd7, 32'd9});
        chk("fill.count", 256'(cnt_a), 256'd4);
        rs = 3'd1;
        #1;
        chk("fill.dout_r1", 256'(dout_a), 256'd7);
        check_all();

        // Eviction.
        step(1'b1, 32'd8, 1'b0);
        chk("evict.ranks", {128'd0, ranks_a}, {128'd0, 32'd5, 32'd7, 32'd8, 32'd9});
        step(1'b1, 32'd0, 1'b0);
        chk("drop0.ranks", {128'd0, ranks_a}, {128'd0, 32'd5, 32'd7, 32'd8, 32'd9});
        chk("drop0.count", 256'(cnt_a), 256'd4);

        // din ignored while din_valid low.
        step(1'b0, 32'hffff_ffff, 1'b0);

        async_reset("midstream");
        chk("post_rst.count", 256'(cnt_a), 256'd0);

        // Duplicates and zero.
        step(1'b1, 32'd0, 1'b0);
        step(1'b1, 32'd3, 1'b0);
        step(1'b1, 32'd3, 1'b0);
        chk("dup.ranks", {128'd0, ranks_a}, {128'd0, 32'd0, 32'd0, 32'd3, 32'd3});
        chk("dup.count", 256'(cnt_a), 256'd3);
        rs = 3'd2;
        #1;
        chk("dup.r2_dout", 256'(dout_a), 256'd0);
        chk("dup.r2_valid", 256'(rv_a), 256'd1);
        chk("uniq.ranks", {128'd0, ranks_b}, {128'd0, 32'd0, 32'd0, 32'd0, 32'd3});
        chk("uniq.count", 256'(cnt_b), 256'd2);

        // Clear collides with a valid sample.
        step(1'b1, 32'd10, 1'b0);
        step(1'b1, 32'd20, 1'b0);
        step(1'b1, 32'd30, 1'b0);
        step(1'b1, 32'd40, 1'b0);
        step(1'b1, 32'd50, 1'b1);
        chk("clr.count", 256'(cnt_a), 256'd0);
        for (int r = 0; r < 4; r++) begin
            rs = 3'(r);
            #1;
            chk("clr.rank_valid", 256'(rv_a), 256'd0);
        end
        step(1'b1, 32'd2, 1'b0);
        chk("clr.after_r0", 256'(ranks_a[31:0]), 256'd2);
        chk("clr.after_count", 256'(cnt_a), 256'd1);

        // Randomised stream; small values often to exercise ties.
        for (int n = 0; n < 10000; n++) begin
            logic        dv;
            logic        cl;
            logic [31:0] d;
            dv = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 99) < 2);
            d  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1999) == 0) async_reset("rand");
            else step(dv, d, cl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/topk_tracker.md
# topk_tracker

Streaming top-K tracker. Maintains the K largest unsigned values accepted since the last reset or clear, held as a sorted register array. Exposes every rank on a flat bus and one selectable rank with a valid flag. It is the parametrised successor of the single-rank second-largest tracker, adding configurable depth K, input qualification, synchronous clear, occupancy tracking and an optional duplicate-rejecting mode.

## Interface
- DATA_WIDTH, 32, sample width; unsigned compare.
- K, 4, number of ranks tracked; legal range is K ≥ 2.
- UNIQUE, 0, duplicate handling:
  - 0: equal values occupy separate ranks.
  - 1: a value equal to any held value is discarded.
- RANK_W, derived, equals $clog2(K).
- CNT_W, derived, equals $clog2(K+1).

- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset. Assertion is immediate; deassertion is synchronous to clk.
- din_valid  in  1  when high, din is offered this cycle.
- din  in  DATA_WIDTH  sample.
- clear  in  1  synchronous flush of all state.
- rank_sel  in  RANK_W  rank to read: 0 = largest, K-1 = K-th largest.
- dout  out  DATA_WIDTH  value at rank_sel. Reads 0 when rank_valid is low.
- rank_valid  out  1  high when rank_sel < count.
- ranks  out  K*DATA_WIDTH  all ranks. Rank r occupies bits [r*DATA_WIDTH +: DATA_WIDTH]. Unoccupied ranks read 0.
- count  out  CNT_W  occupied ranks, saturating at K.

## Operation
- State:
  - val[0..K-1], each DATA_WIDTH bits.
  - occ[0..K-1], one bit per rank.
  - Invariant: occupied ranks are contiguous from 0, and val is non-increasing across occupied ranks.
- Occupancy defines emptiness. A sample of 0 is a legal value and is tracked like any other.
- Accept condition: din_valid = 1 and clear = 0. When UNIQUE = 1, a sample equal to any occupied val is dropped with no state change.
- Insertion:
  - The position p is the first rank r where occ[r] = 0 or din > val[r].
  - Ranks p..K-2 shift down by one. The old rank K-1 is discarded.
  - val[p] ← din and occ[p] ← 1.
  - If no such p exists (the array is full and din ≤ val[K-1]), the sample is dropped.
- Ties with UNIQUE = 0: a new equal value is inserted below the existing equal values (strict >). Since the values are identical, this is not observable.
- One comparator per rank, all evaluated in parallel. Each rank's next value is selected from {hold, din, val[r-1]}. No iterative sort.
- count equals the number of set occ bits. It increments on an accepted insertion while count < K.
- Read path is combinational from registers:
  - dout = occ[rank_sel] ? val[rank_sel] : 0.
  - rank_valid = occ[rank_sel].
- clear: all occ ← 0, all val ← 0, count ← 0.

## Timing
- Reset values: all val = 0, occ = 0, count = 0, dout = 0, rank_valid = 0, ranks = 0.
- Throughput is one sample per cycle, with no stall and no backpressure.
- Latency: a sample accepted at edge N is visible on ranks, count, dout and rank_valid after edge N. Reads return the state as of the last edge.
- clear and din_valid in the same cycle: clear wins. After the edge the array is empty and the sample is lost.
- Reset asserted mid-stream: outputs go to reset values immediately, without waiting for clk.
- rank_sel changes: the response is combinational in the same cycle and has no effect on state.
- din_valid = 0: state holds and din is ignored, including X on din.

## Test plan
- Reset and empty: assert resetn = 0 asynchronously between edges. Then:
  - all outputs read 0 immediately;
  - after release, rank_sel = 0 gives rank_valid = 0 and count = 0.
- Fill and order (K=4, UNIQUE=0): feed 5, 9, 1, 7. Required result:
  - ranks = {9, 7, 5, 1};
  - count = 4;
  - rank_sel = 1 gives dout = 7.
- Eviction: continuing the previous state, feed 8 then 0.
  - After 8: ranks = {9, 8, 7, 5}.
  - 0 is dropped.
  - count stays at 4.
- Duplicates and zero:
  - UNIQUE = 0, feed 0, 3, 3: ranks = {3, 3, 0, –}, count = 3, and rank 2 reads 0 with rank_valid = 1.
  - UNIQUE = 1, same stream: ranks = {3, 0}, count = 2.
- Clear collision: with a full array, drive clear = 1 and din_valid = 1 with din = 50 in the same cycle. Required result:
  - next cycle count = 0 and all rank_valid = 0;
  - then feeding 2 gives ranks[0] = 2 and count = 1.
- Randomised: run 10k samples with random din_valid, clear and rank_sel for K ∈ {2, 4, 8}. Every cycle, compare against a reference model keeping a sorted list truncated to K.
